// File: rtl/cmd_seq_queue_if.sv
// Load and issue handshake bundle for cmd_seq_queue. The sequencer sits on the slave side;
// the loader and issuer sit on the master side.
interface cmd_seq_queue_if #(
   parameter int CMD_W = 64
);
   logic             i_load_valid;
   logic [CMD_W-1:0] i_load_data;
   logic             o_load_ready;
   logic             o_cmd_valid;
   logic [CMD_W-1:0] o_cmd;
   logic             i_cmd_ready;
   logic             i_cmd_done;

   modport slave (
      input  i_load_valid, i_load_data, i_cmd_ready, i_cmd_done,
      output o_load_ready, o_cmd_valid, o_cmd
   );

   modport master (
      output i_load_valid, i_load_data, i_cmd_ready, i_cmd_done,
      input  o_load_ready, o_cmd_valid, o_cmd
   );
endinterface

// File: rtl/cmd_seq_queue.sv
// Command program buffer and sequencer: bulk load, in-order issue with replay,
// outstanding-command throttle and a finished flag once every issued command has completed.
module cmd_seq_queue #(
   parameter  int CMD_W   = 64,
   parameter  int DEPTH   = 16,
   parameter  int MAX_OUT = 4,
   parameter  int REP_W   = 8,
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int IDX_W   = $clog2(DEPTH),
   localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   cmd_seq_queue_if.slave   bus,
   input  logic             i_clear,
   input  logic             i_start,
   input  logic [REP_W-1:0] i_replays,
   output logic [CNT_W-1:0] o_count,
   output logic [OUT_W-1:0] o_outstanding,
   output logic             o_busy,
   output logic             o_finished,
   output logic             o_err,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [REP_W-1:0] pass_q, pass_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             err_q, err_d;

   logic [CMD_W-1:0] mem [DEPTH];

   logic idle_like, load_ready, clear_acc, start_acc, load_wr;
   logic cmd_valid, issue, last_idx, underflow;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Once o_cmd_valid rises, it and o_cmd hold until that transfer (or reset).
   always_comb begin
      idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
      load_ready = idle_like && (count_q < CNT_W'(DEPTH));
      clear_acc  = i_clear && idle_like;
      start_acc  = i_start && idle_like && !i_clear;
      load_wr    = bus.i_load_valid && load_ready && !clear_acc;
      cmd_valid  = (state_q == S_RUN) && (out_q < OUT_W'(MAX_OUT));
      issue      = cmd_valid && bus.i_cmd_ready;
      last_idx   = (CNT_W'(rd_idx_q) == (count_q - CNT_W'(1)));
      underflow  = bus.i_cmd_done && (out_q == '0) && !issue;
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_idx_d = rd_idx_q;
      pass_d   = pass_q;
      out_d    = out_q;
      err_d    = err_q;

      if ((bus.i_load_valid && !load_ready) || underflow) begin
         err_d = 1'b1;
      end

      if (issue && !bus.i_cmd_done) begin
         out_d = out_q + OUT_W'(1);
      end else if (bus.i_cmd_done && !issue && (out_q != '0)) begin
         out_d = out_q - OUT_W'(1);
      end

      if (clear_acc) begin
         count_d = '0;
      end else if (load_wr) begin
         count_d = count_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (clear_acc) begin
               state_d = S_IDLE;
            end else if (start_acc) begin
               if (count_q != '0) begin
                  state_d  = S_RUN;
                  rd_idx_d = '0;
                  pass_d   = i_replays;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (issue) begin
               if (!last_idx) begin
                  rd_idx_d = rd_idx_q + IDX_W'(1);
               end else if (pass_q != '0) begin
                  rd_idx_d = '0;
                  pass_d   = pass_q - REP_W'(1);
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Looking at the next count lets the final done land us in DONE one cycle later.
            if (out_d == '0) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         rd_idx_q <= '0;
         pass_q   <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_idx_q <= rd_idx_d;
         pass_q   <= pass_d;
         out_q    <= out_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (load_wr) begin
         mem[IDX_W'(count_q)] <= bus.i_load_data;
      end
   end

   assign bus.o_load_ready = load_ready;
   assign bus.o_cmd_valid  = cmd_valid;
   assign bus.o_cmd        = cmd_valid ? mem[rd_idx_q] : '0;
   assign o_count          = count_q;
   assign o_outstanding    = out_q;
   assign o_busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign o_finished       = (state_q == S_DONE);
   assign o_err            = err_q;
   assign o_state          = state_q;

endmodule

// File: tb/tb_cmd_seq_queue.sv
// Bench for cmd_seq_queue: directed programs, an issue monitor popping an expected-command queue,
// and a done responder that also tracks the expected outstanding count.
module tb_cmd_seq_queue;
   localparam int CMD_W   = 64;
   localparam int DEPTH   = 16;
   localparam int MAX_OUT = 4;
   localparam int REP_W   = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_seq_queue_if #(.CMD_W(CMD_W)) bus ();

   logic             clear, start;
   logic [REP_W-1:0] replays;
   logic [4:0]       count;
   logic [2:0]       outstanding;
   logic             busy, finished, err;
   logic [1:0]       state;

   cmd_seq_queue #(.CMD_W(CMD_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .REP_W(REP_W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .bus           (bus.slave),
      .i_clear       (clear),
      .i_start       (start),
      .i_replays     (replays),
      .o_count       (count),
      .o_outstanding (outstanding),
      .o_busy        (busy),
      .o_finished    (finished),
      .o_err         (err),
      .o_state       (state)
   );

   // ---------------- scoreboard ----------------
   logic [CMD_W-1:0] exp_q[$];
   logic [CMD_W-1:0] prog[DEPTH];
   int n = 0;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- monitor + done responder ----------------
   int   pend[$];
   int   exp_out = 0;
   int   n_iss = 0;
   int   man_done_cyc = -1;
   int   last_done_cyc = 0;
   bit   auto_done = 0;
   bit   flood = 0;
   logic nd, iss;

   always @(negedge clk) begin
      if (rst) begin
         pend.delete();
         bus.i_cmd_done = 1'b0;
         exp_out = 0;
      end else begin
         chk("outstanding", 64'(outstanding), 64'(exp_out));
         iss = bus.o_cmd_valid && bus.i_cmd_ready;
         if (iss) begin
            n_iss++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue actual=%0h expected=none", bus.o_cmd);
            end else begin
               chk("cmd", bus.o_cmd, exp_q.pop_front());
            end
            if (auto_done) pend.push_back(cyc + 2);
         end
         nd = 1'b0;
         if (pend.size() > 0 && pend[0] == cyc) begin
            void'(pend.pop_front());
            nd = 1'b1;
         end
         if (man_done_cyc == cyc) nd = 1'b1;
         if (flood && outstanding != 3'd0) nd = 1'b1;
         bus.i_cmd_done = nd;
         if (nd) last_done_cyc = cyc + 1;
         if (iss && !nd) exp_out++;
         else if (nd && !iss && exp_out > 0) exp_out--;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_raw(input logic [CMD_W-1:0] d);
      tick();
      bus.i_load_valid = 1'b1;
      bus.i_load_data  = d;
      tick();
      bus.i_load_valid = 1'b0;
   endtask

   task automatic load_word(input logic [CMD_W-1:0] d);
      prog[n] = d;
      n++;
      load_raw(d);
   endtask

   task automatic do_clear();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n = 0;
   endtask

   task automatic start_run(input int r);
      for (int p = 0; p <= r; p++)
         for (int i = 0; i < n; i++) exp_q.push_back(prog[i]);
      tick();
      replays = REP_W'(r);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_fin(input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!finished && k < 400);
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=0 expected=finished", name);
      end else begin
         chk({name, "_fin_latency"}, 64'(cyc), 64'(last_done_cyc));
      end
      chk({name, "_exp_q_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset(input string name);
      chk({name, "_valid"}, 64'(bus.o_cmd_valid), 64'd0);
      chk({name, "_cmd"}, bus.o_cmd, 64'd0);
      chk({name, "_load_ready"}, 64'(bus.o_load_ready), 64'd1);
      chk({name, "_count"}, 64'(count), 64'd0);
      chk({name, "_outstanding"}, 64'(outstanding), 64'd0);
      chk({name, "_busy"}, 64'(busy), 64'd0);
      chk({name, "_finished"}, 64'(finished), 64'd0);
      chk({name, "_err"}, 64'(err), 64'd0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int base;
      int k;
      rst = 1'b1;
      clear = 1'b0;
      start = 1'b0;
      replays = '0;
      bus.i_load_valid = 1'b0;
      bus.i_load_data  = '0;
      bus.i_cmd_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset0");
      tick();
      rst = 1'b0;

      // single pass, done 2 cycles after each issue
      auto_done = 1;
      bus.i_cmd_ready = 1'b1;
      load_word(64'h11);
      load_word(64'h22);
      load_word(64'h33);
      @(negedge clk);
      chk("t1_count", 64'(count), 64'd3);
      base = n_iss;
      start_run(0);
      wait_fin("t1");
      chk("t1_issues", 64'(n_iss - base), 64'd3);
      chk("t1_busy", 64'(busy), 64'd0);

      // same program, two replays
      base = n_iss;
      start_run(2);
      wait_fin("t2");
      chk("t2_issues", 64'(n_iss - base), 64'd9);

      // throttle at MAX_OUT with no completions
      auto_done = 0;
      do_clear();
      for (int i = 0; i < 8; i++) load_word(64'h30 + 64'(i));
      base = n_iss;
      start_run(0);
      repeat (10) @(negedge clk);
      chk("t3_issues_throttled", 64'(n_iss - base), 64'd4);
      chk("t3_valid_low", 64'(bus.o_cmd_valid), 64'd0);
      chk("t3_outstanding_max", 64'(outstanding), 64'd4);
      man_done_cyc = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      chk("t3_valid_reopen", 64'(bus.o_cmd_valid), 64'd1);
      chk("t3_outstanding_after_done", 64'(outstanding), 64'd3);
      @(negedge clk);
      chk("t3_fifth_issue", 64'(n_iss - base), 64'd5);
      flood = 1;
      wait_fin("t3");
      flood = 0;

      // full program, overflow load, start with ready low
      auto_done = 1;
      do_clear();
      for (int i = 0; i < DEPTH; i++) load_word(64'hA0 + 64'(i));
      @(negedge clk);
      chk("t4_load_ready_full", 64'(bus.o_load_ready), 64'd0);
      chk("t4_count_full", 64'(count), 64'(DEPTH));
      load_raw(64'hDEAD);
      @(negedge clk);
      chk("t4_err_overflow", 64'(err), 64'd1);
      chk("t4_count_kept", 64'(count), 64'(DEPTH));
      bus.i_cmd_ready = 1'b0;
      start_run(0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 64'(bus.o_cmd_valid), 64'd1);
         chk("t4_hold_cmd", bus.o_cmd, prog[0]);
      end
      tick();
      bus.i_cmd_ready = 1'b1;
      wait_fin("t4");

      // reset clears the sticky error
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_reset("reset1");
      tick();
      rst = 1'b0;
      n = 0;

      // empty program start, done in IDLE
      start_run(0);
      @(negedge clk);
      chk("t5_finished_empty", 64'(finished), 64'd1);
      chk("t5_no_valid", 64'(bus.o_cmd_valid), 64'd0);
      do_clear();
      @(negedge clk);
      chk("t5_idle_after_clear", 64'(finished), 64'd0);
      man_done_cyc = cyc + 1;
      repeat (3) @(negedge clk);
      chk("t5_err_underflow", 64'(err), 64'd1);

      // async reset mid-run, then recover
      auto_done = 0;
      load_word(64'h41);
      load_word(64'h42);
      load_word(64'h43);
      start_run(0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (outstanding != 3'd2 && k < 20);
      chk("t6_reached_out2", 64'(outstanding), 64'd2);
      #1;
      rst = 1'b1;
      #2;
      check_reset("reset_async");
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      n = 0;
      auto_done = 1;
      load_word(64'h55);
      start_run(0);
      wait_fin("t6");
      chk("t6_count", 64'(count), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/cmd_seq_queue.md
Name: cmd_seq_queue

Overview:
Parametrised command program buffer and sequencer that feeds the issuer. It replaces the bench-side preloaded FIFO and the software "queue empty then finished" polling with hardware. A program of up to DEPTH commands is bulk-loaded through a valid/ready port, then issued in order, optionally replayed N times. The block tracks outstanding (issued but not completed) commands, throttles issue at a configurable limit, and raises o_finished when every issued command has completed.

Parameters:
CMD_W, 64, command word width in bits
DEPTH, 16, program buffer entries (any value >= 2)
MAX_OUT, 4, maximum issued-but-not-completed commands (>= 1)
REP_W, 8, width of the replay-count input

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  asynchronous, active-high reset
i_load_valid  in  1  load-port write request
i_load_data  in  CMD_W  command to append to the program
o_load_ready  out  1  high in IDLE/DONE while count < DEPTH
i_clear  in  1  empties the program (count := 0); honoured in IDLE/DONE only
i_start  in  1  begin execution; honoured in IDLE/DONE only
i_replays  in  REP_W  extra passes, sampled at start (0 = single pass)
o_cmd_valid  out  1  command available to the issuer
o_cmd  out  CMD_W  current command, stable while valid && !ready
i_cmd_ready  in  1  issuer accepts o_cmd this cycle
i_cmd_done  in  1  single-cycle completion pulse, one per finished command
o_count  out  $clog2(DEPTH+1)  program length
o_outstanding  out  $clog2(MAX_OUT+1)  issued-not-completed count
o_busy  out  1  high in RUN or DRAIN
o_finished  out  1  high in DONE
o_err  out  1  sticky: done underflow, or load attempted while full or busy

Behaviour:
- Reset (async, i_rst=1): state IDLE; count, rd_idx, pass, outstanding := 0; o_err := 0. All outputs 0 except o_load_ready = 1. Buffer contents are undefined. Reset mid-RUN aborts immediately with no completion reported.
- Load: write occurs when i_load_valid && o_load_ready. Data goes to mem[count]; count increments. i_load_valid while not ready sets o_err; data is dropped.
- i_clear has priority over a same-cycle load. i_clear with i_start is illegal: clear wins, start is ignored.
- FSM:
  - IDLE/DONE + i_start, count>0 -> RUN. rd_idx := 0; pass := i_replays; o_finished drops on the next cycle.
  - IDLE/DONE + i_start, count==0 -> DONE, o_finished = 1 the next cycle.
  - RUN: o_cmd_valid = (outstanding < MAX_OUT); o_cmd = mem[rd_idx]. The first valid appears the cycle after start is sampled.
  - Issue handshake = o_cmd_valid && i_cmd_ready. On issue, rd_idx increments. At rd_idx==count-1: if pass>0, rd_idx := 0 and pass decrements; else -> DRAIN.
  - DRAIN: o_cmd_valid = 0. -> DONE when outstanding==0. This includes the same cycle in which the last done lowers it to 0, so DONE is visible one cycle after the final done.
  - DONE: o_finished = 1 until the next accepted i_start or i_clear. A clear returns the FSM to IDLE.
- Once valid is asserted, o_cmd stays constant until the handshake. Valid never drops without a handshake, except on reset.
- Outstanding counter: +1 on issue, -1 on i_cmd_done. Simultaneous issue and done leave it unchanged.
  - i_cmd_done with outstanding==0 (and no same-cycle issue) is ignored and sets o_err.
  - The counter never exceeds MAX_OUT.
- The throttle uses the registered outstanding value, so a done pulse re-enables valid on the following cycle.
- i_cmd_done is accepted in any state. A late done in DONE while outstanding==0 sets o_err.
- i_start while busy is ignored; it does not set o_err.
- Total issues per run = count*(i_replays+1).

Test Plan:
- Load 0x11,0x22,0x33 (DEPTH=16), start, replays=0, ready=1, done returned 2 cycles after each issue -> o_cmd sequence 11,22,33; o_finished rises one cycle after the 3rd done; o_count=3.
- Same program with replays=2 -> 9 issues, order 11,22,33 x3; pass wraps correctly; finished only after the 9th done.
- MAX_OUT=4, no done pulses, ready=1, 8-entry program -> exactly 4 issues, then valid low with outstanding=4. Pulse one done -> a 5th issue on the cycle after the done.
- Load DEPTH entries -> o_load_ready low. An extra load sets o_err and count stays DEPTH. Start with ready held low -> o_cmd holds mem[0] stable.
- Start with count=0 -> DONE next cycle, no valid. A done pulse in IDLE -> o_err=1. Issue and done in the same cycle -> outstanding unchanged.
- Assert i_rst mid-RUN (outstanding=2) -> all outputs clear asynchronously and o_load_ready=1. After release, reload 1 entry and run to finished.
